// File: rtl/imem_resp.sv
// imem_resp: instruction-memory responder for the tamarisc fetch stage.
// Returns the word at the fetch address combinationally. A byte-serial loader
// fills the array while the core is held.
// Optional fetch fault checking is enabled by defining IMEM_FAULT_CHK_EN;
// without it, fault_o is tied low and addresses wrap modulo DEPTH words.
module imem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [31:0]              im_addr_i,
  output logic [31:0]              im_dout_o,
  input  logic                     ld_start_i,
  input  logic                     ld_valid_i,
  input  logic [7:0]               ld_byte_i,
  output logic                     ld_ready_o,
  input  logic                     ld_done_i,
  output logic                     hold_o,
  output logic [$clog2(DEPTH):0]   ld_count_o,
  output logic                     ld_ovf_o,
  output logic                     fault_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     lane_q;
  logic [23:0]    part_q;
  logic [CW-1:0]  count_q;
  logic           ovf_q;

  logic           restart;
  logic           take_byte;
  logic           flush_end;
  logic           wr_req;
  logic [31:0]    wr_data;
  logic           mem_full;
  logic           mem_we;

  logic [31:0]    mem [DEPTH];

  logic [31:0]    rd_off;
  logic [AW-1:0]  rd_idx;
  logic           fetch_fault;
  logic           unused_addr_bits;

  assign mem_full   = (count_q == FULL_CNT);
  assign mem_we     = rst_n_i && wr_req && !mem_full;
  assign ld_count_o = count_q;
  assign ld_ovf_o   = ovf_q;

  // State register for the loader FSM
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Loader next-state logic, handshake outputs and word-write requests
  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    take_byte  = 1'b0;
    flush_end  = 1'b0;
    wr_req     = 1'b0;
    wr_data    = 32'h0;
    ld_ready_o = 1'b0;
    hold_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          restart = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        hold_o     = 1'b1;
        if (ld_start_i) begin
          restart = 1'b1;
        end else begin
          if (ld_valid_i) begin
            take_byte = 1'b1;
            if (lane_q == 2'd3) begin
              wr_req  = 1'b1;
              wr_data = {ld_byte_i, part_q};
            end
          end
          if (ld_done_i) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        hold_o = 1'b1;
        if (ld_start_i) begin
          restart = 1'b1;
          state_d = LOAD;
        end else begin
          flush_end = 1'b1;
          state_d   = IDLE;
          if (lane_q != 2'd0) begin
            wr_req = 1'b1;
            if (lane_q == 2'd1) begin
              wr_data = {24'h0, part_q[7:0]};
            end else if (lane_q == 2'd2) begin
              wr_data = {16'h0, part_q[15:0]};
            end else begin
              wr_data = {8'h0, part_q};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte packing, write pointer/count and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lane_q  <= 2'd0;
      part_q  <= 24'h0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (restart) begin
      lane_q  <= 2'd0;
      part_q  <= 24'h0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (take_byte) begin
        lane_q <= lane_q + 2'd1;
        unique case (lane_q)
          2'd0:    part_q[7:0]   <= ld_byte_i;
          2'd1:    part_q[15:8]  <= ld_byte_i;
          2'd2:    part_q[23:16] <= ld_byte_i;
          default: ;
        endcase
      end
      if (flush_end) begin
        lane_q <= 2'd0;
      end
      if (wr_req) begin
        if (mem_full) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end
    end
  end

  // Single write port into the (unreset) instruction array
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_off           = im_addr_i - BASE_ADDR;
  assign rd_idx           = rd_off[AW+1:2];
  assign unused_addr_bits = ^{rd_off[31:AW+2], rd_off[1:0]};

`ifdef IMEM_FAULT_CHK_EN
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  assign fetch_fault = (im_addr_i[1:0] != 2'b00) ||
                       (im_addr_i < BASE_ADDR) ||
                       ({1'b0, im_addr_i} >= ADDR_LIMIT);
`else
  assign fetch_fault = 1'b0;
`endif

  // Combinational fetch response: bubble while held, NOP on a faulty fetch
  always_comb begin
    im_dout_o = mem[rd_idx];
    fault_o   = 1'b0;
    if (hold_o) begin
      im_dout_o = 32'h0;
    end else if (fetch_fault) begin
      im_dout_o = 32'h0000_0013;
      fault_o   = 1'b1;
    end
  end

endmodule

// File: doc/imem_resp.md
# imem_resp

Instruction-memory responder for the tamarisc core: the memory end of the fetch interface. It returns the 32-bit instruction word for the fetch stage's word-aligned address in the same cycle, matching the fetch stage's register-on-edge capture. It also provides a byte-serial program loader: a small FSM packs little-endian bytes into words and fills the array while the core is held.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, ≥4
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  synchronous reset, active-low
- im_addr_i  in  32  fetch byte address (driven from the PC)
- im_dout_o  out  32  instruction word for im_addr_i, combinational
- ld_start_i  in  1  begin (or restart) a program load
- ld_valid_i  in  1  loader byte valid
- ld_byte_i  in  8  loader byte
- ld_ready_o  out  1  loader byte may be accepted
- ld_done_i  in  1  end of program image
- hold_o  out  1  core must stall/flush; high while loading
- ld_count_o  out  $clog2(DEPTH)+1  words written by the current/last load
- ld_ovf_o  out  1  sticky: image exceeded DEPTH words
- fault_o  out  1  fetch fault (see Configuration)

## Operation
- Read index: idx = (im_addr_i − BASE_ADDR) >> 2, truncated to $clog2(DEPTH) bits; im_addr_i[1:0] ignored for indexing.
- im_dout_o = mem[idx] when hold_o=0; forced to 32'h0 when hold_o=1. The fetch stage treats zero as a bubble.
- Array contents are not reset. The array has one write port, owned by the loader.
- FSM states:
  - IDLE: ld_ready_o=0, hold_o=0. ld_start_i=1 → LOAD; clear wr_ptr, byte lane, ld_count_o, ld_ovf_o.
  - LOAD: ld_ready_o=1, hold_o=1. A byte is accepted when ld_valid_i && ld_ready_o.
    - Byte lane k (0..3) goes to bits [8k+7:8k]; lane increments.
    - On lane-3 acceptance, the word is written to mem[wr_ptr] and wr_ptr/ld_count_o increment. The lane wraps to 0.
    - ld_done_i=1 → FLUSH.
  - FLUSH: ld_ready_o=0, hold_o=1. If lane≠0, the partial word is written with unfilled upper bytes zero and ld_count_o increments. Then → IDLE.
- Overflow: if ld_count_o==DEPTH when a word would be written, the write is dropped, ld_count_o holds, and ld_ovf_o is set. ld_ovf_o stays set until the next ld_start_i or reset.
- Simultaneous events:
  - ld_valid_i with ld_done_i in LOAD: the byte is accepted first, then FSM → FLUSH. A lane-3 byte writes that cycle and FLUSH writes nothing.
  - ld_start_i in LOAD or FLUSH restarts: pointer, lane, count and ovf are cleared, state = LOAD, and any partial word is discarded.
  - ld_start_i and ld_done_i together: ld_start_i wins.
- Reset mid-load: the FSM goes to IDLE. Words already written remain. Partial bytes are lost.

## Timing
- Read latency 0: im_dout_o follows im_addr_i combinationally, so the fetch stage captures it at the next edge.
- A word written at edge N is readable from cycle N+1.
- ld_start_i at edge N: LOAD from N+1; ld_ready_o and hold_o high in cycle N+1.
- ld_done_i at edge N: FLUSH during cycle N+1; IDLE and hold_o=0 from N+2.
- Throughput: one byte per cycle in LOAD.
- Reset values: ld_ready_o=0, hold_o=0, ld_count_o=0, ld_ovf_o=0, fault_o=0, FSM=IDLE, lane=0, wr_ptr=0.

## Configuration
- IMEM_FAULT_CHK_EN defined:
  - Condition: the fetch is faulty if im_addr_i[1:0]≠0, or im_addr_i < BASE_ADDR, or im_addr_i ≥ BASE_ADDR+4·DEPTH.
  - Response when hold_o=0: im_dout_o = 32'h0000_0013 (NOP) and fault_o=1, both combinational in the same cycle.
- Undefined: no fault check, fault_o tied 0, and the address wraps modulo DEPTH words.

## Test plan
- Reset then load: ld_start_i; bytes 13,00,00,00,93,00,10,00; ld_done_i. Expect ld_count_o=2, mem[0]=32'h0000_0013, mem[1]=32'h0010_0093, hold_o low 2 cycles after done.
- Partial flush: load bytes AA,BB,CC then ld_done_i. Expect mem[0]=32'h00CC_BBAA and ld_count_o=1.
- Hold/bubble: during LOAD, im_addr_i=0 gives im_dout_o=0. After IDLE, im_addr_i=4 gives 32'h0010_0093 in the same cycle.
- Overflow with DEPTH=4: load 5 words. Expect ld_count_o=4 and ld_ovf_o=1. mem[0..3] hold words 0..3; word 4 is dropped. A new ld_start_i clears ld_ovf_o.
- Restart and reset mid-load: after 2 bytes, pulse ld_start_i, then load 4 bytes; mem[0] gets the new word only. A separate run with rst_n_i=0 mid-load returns to IDLE with outputs at reset values.
- With IMEM_FAULT_CHK_EN: im_addr_i=32'h2 gives 32'h0000_0013 and fault_o=1; im_addr_i=4·DEPTH gives the same. Without the macro, fault_o=0 and 4·DEPTH reads mem[0].
